// File: rtl/c5_niosii_spi_slvsec_key_db_pio_pkg.sv
// -----------------------------------------------------------------------------
// c5_niosii_spi_slvsec_key_db_pio_pkg
// Shared constants for the debounced key PIO: register word addresses,
// default parameter values and the prescaler wrap helper.
// -----------------------------------------------------------------------------
package c5_niosii_spi_slvsec_key_db_pio_pkg;

  // Avalon-MM word addresses of the register file
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN   = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN   = 3'd4;
  localparam logic [2:0] ADDR_DB_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_RAW       = 3'd6;

  // Default parameter values
  localparam int          DEF_WIDTH         = 4;
  localparam int          DEF_DB_SAMPLES    = 4;
  localparam logic [15:0] DEF_DB_PERIOD_RST = 16'd50000;

  // True on the last count of a period; a zero period never wraps (bypass).
  // ">=" keeps the prescaler from running away if the count ever exceeds
  // the period.
  function automatic logic presc_at_wrap(input logic [15:0] count,
                                         input logic [15:0] period);
    presc_at_wrap = (period != 16'd0) && (count >= (period - 16'd1));
  endfunction

endpackage

// File: rtl/c5_niosii_spi_slvsec_key_db_pio_if.sv
// -----------------------------------------------------------------------------
// c5_niosii_spi_slvsec_key_db_pio_if
// Avalon-MM slave bus bundle for the debounced key PIO.
//   address[2:0]    word address           (master -> slave)
//   chipselect      slave select           (master -> slave)
//   write_n         active-low write       (master -> slave)
//   writedata[31:0] write data             (master -> slave)
//   readdata[31:0]  registered read data   (slave -> master)
// -----------------------------------------------------------------------------
interface c5_niosii_spi_slvsec_key_db_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/c5_niosii_spi_slvsec_key_db_chan.sv
// -----------------------------------------------------------------------------
// c5_niosii_spi_slvsec_key_db_chan
// One key channel: 2-flop synchroniser, tick-driven debounce counter and
// edge detect.
//   clk, reset   clock, synchronous active-high reset
//   raw_in       asynchronous key input
//   tick         one-cycle debounce sample strobe from the prescaler
//   bypass       debounce disabled: level tracks the synchronised input
//   rise_en      capture 0->1 level changes
//   fall_en      capture 1->0 level changes
//   sync_out     synchronised input
//   level        debounced level
//   edge_set     request to set this channel's capture bit (same cycle the
//                level register takes its new value)
// -----------------------------------------------------------------------------
module c5_niosii_spi_slvsec_key_db_chan
  import c5_niosii_spi_slvsec_key_db_pio_pkg::*;
#(
  parameter int   DB_SAMPLES = DEF_DB_SAMPLES,
  parameter logic RST_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic tick,
  input  logic bypass,
  input  logic rise_en,
  input  logic fall_en,
  output logic sync_out,
  output logic level,
  output logic edge_set
);

  // Counter value on the last differing tick before the level toggles
  localparam logic [3:0] LAST_CNT = 4'(DB_SAMPLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic       level_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Debounce next-state: count consecutive differing ticks, toggle on the last
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (bypass) begin
      level_d = sync2_q;
      cnt_d   = 4'd0;
    end else if (tick) begin
      if (sync2_q != level_q) begin
        if (cnt_q >= LAST_CNT) begin
          level_d = ~level_q;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = 4'd0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchroniser, debounced level and stable counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RST_LEVEL;
      sync2_q <= RST_LEVEL;
      level_q <= RST_LEVEL;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Edge is seen on the next-state so capture lands with the level update
  assign edge_set = (~level_q &  level_d & rise_en) |
                    ( level_q & ~level_d & fall_en);
  assign sync_out = sync2_q;
  assign level    = level_q;

endmodule

// File: rtl/c5_niosii_spi_slvsec_key_db_pio.sv
// -----------------------------------------------------------------------------
// c5_niosii_spi_slvsec_key_db_pio
// Debounced key PIO with edge capture and level interrupt on an Avalon-MM
// slave.
//   clk, reset   clock, synchronous active-high reset
//   bus          Avalon-MM slave (address, chipselect, write_n, writedata,
//                readdata with one cycle read latency)
//   in_port      asynchronous raw key inputs
//   irq          |(EDGE_CAP & IRQ_MASK)
// Register map: 0 DATA(RO) 1 RISE_EN 2 IRQ_MASK 3 EDGE_CAP(W1C) 4 FALL_EN
//               5 DB_PERIOD[15:0] 6 RAW(RO) 7 zero
// -----------------------------------------------------------------------------
module c5_niosii_spi_slvsec_key_db_pio
  import c5_niosii_spi_slvsec_key_db_pio_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter int               DB_SAMPLES    = DEF_DB_SAMPLES,
  parameter logic [15:0]      DB_PERIOD_RST = DEF_DB_PERIOD_RST,
  parameter logic [WIDTH-1:0] IN_RST_LEVEL  = {WIDTH{1'b1}}
) (
  input  logic                                  clk,
  input  logic                                  reset,
  c5_niosii_spi_slvsec_key_db_pio_if.slave      bus,
  input  logic [WIDTH-1:0]                      in_port,
  output logic                                  irq
);

  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;
  logic             period_wr_s;
  logic [WIDTH-1:0] w1c_s;
  logic             tick_s;
  logic             bypass_s;

  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] set_s;

  logic [WIDTH-1:0] rise_en_q,  rise_en_d;
  logic [WIDTH-1:0] fall_en_q,  fall_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [15:0]      db_period_q, db_period_d;
  logic [15:0]      presc_q, presc_d;
  logic [31:0]      readdata_q, readdata_d;

  // Upper write-data bits are never stored
  logic unused_wdata_s;
  assign unused_wdata_s = ^bus.writedata[31:16];

  assign wr_s     = bus.chipselect & ~bus.write_n;
  assign wdata_s  = bus.writedata[WIDTH-1:0];
  assign tick_s   = presc_at_wrap(presc_q, db_period_q);
  assign bypass_s = (db_period_q == 16'd0);

  // Per-channel synchroniser, debounce and edge detect
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    c5_niosii_spi_slvsec_key_db_chan #(
      .DB_SAMPLES (DB_SAMPLES),
      .RST_LEVEL  (IN_RST_LEVEL[i])
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (in_port[i]),
      .tick     (tick_s),
      .bypass   (bypass_s),
      .rise_en  (rise_en_q[i]),
      .fall_en  (fall_en_q[i]),
      .sync_out (sync_s[i]),
      .level    (level_s[i]),
      .edge_set (set_s[i])
    );
  end

  // Register write decode
  always_comb begin
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    irq_mask_d  = irq_mask_q;
    db_period_d = db_period_q;
    w1c_s       = {WIDTH{1'b0}};
    period_wr_s = 1'b0;
    if (wr_s) begin
      case (bus.address)
        ADDR_RISE_EN:   rise_en_d  = wdata_s;
        ADDR_IRQ_MASK:  irq_mask_d = wdata_s;
        ADDR_EDGE_CAP:  w1c_s      = wdata_s;
        ADDR_FALL_EN:   fall_en_d  = wdata_s;
        ADDR_DB_PERIOD: begin
          db_period_d = bus.writedata[15:0];
          period_wr_s = 1'b1;
        end
        default: period_wr_s = 1'b0;
      endcase
    end else begin
      period_wr_s = 1'b0;
    end
  end

  // Edge capture: clear-by-write first, then set so a same-cycle set wins
  always_comb begin
    edge_cap_d = (edge_cap_q & ~w1c_s) | set_s;
  end

  // Prescaler: restart on period write, wrap on tick, parked at 0 in bypass
  always_comb begin
    presc_d = presc_q;
    if (period_wr_s) begin
      presc_d = 16'd0;
    end else if (tick_s || bypass_s) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    readdata_d = 32'd0;
    case (bus.address)
      ADDR_DATA:      readdata_d = 32'(level_s);
      ADDR_RISE_EN:   readdata_d = 32'(rise_en_q);
      ADDR_IRQ_MASK:  readdata_d = 32'(irq_mask_q);
      ADDR_EDGE_CAP:  readdata_d = 32'(edge_cap_q);
      ADDR_FALL_EN:   readdata_d = 32'(fall_en_q);
      ADDR_DB_PERIOD: readdata_d = {16'd0, db_period_q};
      ADDR_RAW:       readdata_d = 32'(sync_s);
      default:        readdata_d = 32'd0;
    endcase
  end

  // Register file, prescaler and read data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en_q   <= {WIDTH{1'b0}};
      fall_en_q   <= {WIDTH{1'b1}};
      irq_mask_q  <= {WIDTH{1'b0}};
      edge_cap_q  <= {WIDTH{1'b0}};
      db_period_q <= DB_PERIOD_RST;
      presc_q     <= 16'd0;
      readdata_q  <= 32'd0;
    end else begin
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      db_period_q <= db_period_d;
      presc_q     <= presc_d;
      readdata_q  <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_c5_niosii_spi_slvsec_key_db_pio.sv
module tb_c5_niosii_spi_slvsec_key_db_pio;

  localparam int NCH     = 4;
  localparam int SAMPLES = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] in_port;
  logic           irq;

  int checks = 0;
  int errors = 0;

  c5_niosii_spi_slvsec_key_db_pio_if bus ();

  c5_niosii_spi_slvsec_key_db_pio #(
    .WIDTH         (NCH),
    .DB_SAMPLES    (SAMPLES),
    .DB_PERIOD_RST (16'd50000),
    .IN_RST_LEVEL  (4'hF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [3:0]  m_level, m_seen1, m_seen2;
  logic [3:0]  m_rise, m_fall, m_mask, m_cap;
  int          m_run [NCH];
  logic [15:0] m_period;
  int          m_phase;
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic model_reset();
    m_level  = 4'hF;
    m_seen1  = 4'hF;
    m_seen2  = 4'hF;
    m_rise   = 4'h0;
    m_fall   = 4'hF;
    m_mask   = 4'h0;
    m_cap    = 4'h0;
    m_period = 16'd50000;
    m_phase  = 0;
    m_rd     = 32'd0;
    m_irq    = 1'b0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs present before it
  task automatic model_step();
    logic       wr;
    logic       tick;
    int         p;
    logic [3:0] newlvl;
    logic [3:0] clr;
    if (reset) begin
      model_reset();
      return;
    end
    wr = bus.chipselect && !bus.write_n;
    case (bus.address)
      3'd0:    m_rd = {28'd0, m_level};
      3'd1:    m_rd = {28'd0, m_rise};
      3'd2:    m_rd = {28'd0, m_mask};
      3'd3:    m_rd = {28'd0, m_cap};
      3'd4:    m_rd = {28'd0, m_fall};
      3'd5:    m_rd = {16'd0, m_period};
      3'd6:    m_rd = {28'd0, m_seen2};
      default: m_rd = 32'd0;
    endcase
    p = int'(m_period);
    tick = (p != 0) && ((m_phase % p) == p - 1);
    newlvl = m_level;
    for (int i = 0; i < NCH; i++) begin
      if (p == 0) begin
        newlvl[i] = m_seen2[i];
        m_run[i]  = 0;
      end else if (tick) begin
        if (m_seen2[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == SAMPLES) begin
            newlvl[i] = m_seen2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    clr = (wr && bus.address == 3'd3) ? bus.writedata[3:0] : 4'h0;
    m_cap = m_cap & ~clr;
    for (int i = 0; i < NCH; i++) begin
      if (m_level[i] == 1'b0 && newlvl[i] == 1'b1 && m_rise[i]) m_cap[i] = 1'b1;
      if (m_level[i] == 1'b1 && newlvl[i] == 1'b0 && m_fall[i]) m_cap[i] = 1'b1;
    end
    m_level = newlvl;
    m_seen2 = m_seen1;
    m_seen1 = in_port;
    if (wr && bus.address == 3'd5) begin
      m_period = bus.writedata[15:0];
      m_phase  = 0;
    end else begin
      m_phase = m_phase + 1;
    end
    if (wr && bus.address == 3'd1) m_rise = bus.writedata[3:0];
    if (wr && bus.address == 3'd2) m_mask = bus.writedata[3:0];
    if (wr && bus.address == 3'd4) m_fall = bus.writedata[3:0];
    m_irq = |(m_cap & m_mask);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    bus.address = a;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] exp_rst [8];
    exp_rst[0] = 32'hF; exp_rst[1] = 32'h0; exp_rst[2] = 32'h0; exp_rst[3] = 32'h0;
    exp_rst[4] = 32'hF; exp_rst[5] = 32'd50000; exp_rst[6] = 32'hF; exp_rst[7] = 32'h0;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: readdata=%h irq=%b expected 0/0", bus.readdata, irq);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a));
      checks++;
      if (bus.readdata !== exp_rst[a]) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, bus.readdata, exp_rst[a]);
      end
    end
  endtask

  task automatic test_hold_low();
    int n;
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b0;
    bus_write(3'd5, 32'd4);
    bus.address = 3'd0;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      checks++;
      if (bus.readdata !== m_rd) begin
        errors++;
        $display("FAIL hold_low_data: got %h expected %h", bus.readdata, m_rd);
      end
      if (bus.readdata[0] === 1'b0) break;
    end
    checks++;
    if (n < 14 || n > 22) begin
      errors++;
      $display("FAIL hold_low_latency: got %0d cycles expected 14..22", n);
    end
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'h1 || bus.readdata !== m_rd) begin
      errors++;
      $display("FAIL hold_low_edgecap: got %h expected %h", bus.readdata, 32'h1);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL hold_low_irq: got %b expected 1", irq);
    end
  endtask

  task automatic test_glitch();
    bus_write(3'd3, 32'hF);
    bus.address = 3'd0;
    in_port[1] = 1'b0;
    repeat (10) step();
    in_port[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (bus.readdata !== 32'hE || bus.readdata !== m_rd) begin
        errors++;
        $display("FAIL glitch_data: got %h expected %h", bus.readdata, 32'hE);
      end
    end
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL glitch_edgecap: got %h irq=%b expected 0 irq=0", bus.readdata, irq);
    end
  endtask

  task automatic test_w1c();
    bus_write(3'd1, 32'h1);
    bus_write(3'd5, 32'd0);
    in_port = 4'b1101;
    repeat (5) step();
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'h3) begin
      errors++;
      $display("FAIL w1c_setup: got %h expected %h", bus.readdata, 32'h3);
    end
    bus_write(3'd3, 32'h1);
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'h2 || bus.readdata !== m_rd) begin
      errors++;
      $display("FAIL w1c_clear: got %h expected %h", bus.readdata, 32'h2);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_simultaneous();
    in_port = 4'b1001;
    step();
    step();
    bus_write(3'd3, 32'h4);
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'h6 || bus.readdata !== m_rd) begin
      errors++;
      $display("FAIL set_beats_clear: got %h expected %h", bus.readdata, 32'h6);
    end
  endtask

  task automatic test_bypass();
    bus_write(3'd1, 32'hF);
    bus_write(3'd4, 32'h0);
    in_port = 4'hF;
    repeat (4) step();
    bus_write(3'd3, 32'hF);
    bus.address = 3'd0;
    in_port = 4'hE;
    repeat (4) step();
    checks++;
    if (bus.readdata !== 32'hE || bus.readdata !== m_rd) begin
      errors++;
      $display("FAIL bypass_fall_data: got %h expected %h", bus.readdata, 32'hE);
    end
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL bypass_fall_cap: got %h expected %h", bus.readdata, 32'h0);
    end
    in_port = 4'hF;
    bus.address = 3'd0;
    repeat (4) step();
    checks++;
    if (bus.readdata !== 32'hF) begin
      errors++;
      $display("FAIL bypass_rise_data: got %h expected %h", bus.readdata, 32'hF);
    end
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'h1 || bus.readdata !== m_rd) begin
      errors++;
      $display("FAIL bypass_rise_cap: got %h expected %h", bus.readdata, 32'h1);
    end
  endtask

  task automatic test_reset_mid();
    in_port = 4'h0;
    repeat (4) step();
    in_port = 4'hF;
    repeat (4) step();
    bus_write(3'd2, 32'hF);
    checks++;
    if (irq !== 1'b1 || m_cap !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_setup: irq=%b model_cap=%h expected 1/F", irq, m_cap);
    end
    bus_write(3'd5, 32'd4);
    in_port[0] = 1'b0;
    repeat (8) step();
    reset = 1'b1;
    bus.address = 3'd3;
    step();
    checks++;
    if (bus.readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_out: readdata=%h irq=%b expected 0/0", bus.readdata, irq);
    end
    reset = 1'b0;
    bus_read(3'd3);
    checks++;
    if (bus.readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_edgecap: got %h expected 0", bus.readdata);
    end
    bus_read(3'd5);
    checks++;
    if (bus.readdata !== 32'd50000) begin
      errors++;
      $display("FAIL reset_mid_period: got %0d expected 50000", bus.readdata);
    end
    in_port = 4'hF;
    repeat (3) step();
  endtask

  task automatic test_random();
    logic [2:0] a;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      a = 3'($urandom_range(0, 7));
      bus.address = a;
      bus.writedata = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        if (a == 3'd5) bus.writedata = 32'($urandom_range(0, 3));
      end else begin
        bus.chipselect = 1'($urandom_range(0, 1));
        bus.write_n    = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) in_port[$urandom_range(0, NCH - 1)] ^= 1'b1;
      step();
      checks++;
      if (bus.readdata !== m_rd || irq !== m_irq) begin
        errors++;
        $display("FAIL random_cycle%0d: readdata=%h irq=%b expected %h/%b",
                 c, bus.readdata, irq, m_rd, m_irq);
      end
    end
    reset = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    in_port        = 4'hF;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    model_reset();
    test_reset();
    test_hold_low();
    test_glitch();
    test_w1c();
    test_simultaneous();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
